// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : game_sequencer
//  Purpose  : Turn sequencer for a small board game. It clears the board
//             memory, accepts or rejects player moves, enforces an optional
//             per-turn timeout, and reports win/tie results from an external
//             win checker.
//  Revision : 1.0 - initial release
// ============================================================================
module game_sequencer #(
  parameter int NPLAYERS = 2,
  parameter int NCELLS   = 9,
  parameter int ADDR_W   = 4,
  parameter int TIMEOUT  = 0,
  parameter int TMR_W    = 16
) (
  input  logic                        ph1_i,
  input  logic                        reset_i,
  input  logic                        new_game_i,
  input  logic [1:0]                  start_player_i,
  input  logic                        move_valid_i,
  input  logic [ADDR_W-1:0]           move_addr_i,
  input  logic                        win_detect_i,
  output logic                        wr_en_o,
  output logic [ADDR_W-1:0]           wr_addr_o,
  output logic [1:0]                  wr_data_o,
  output logic [1:0]                  cur_player_o,
  output logic                        move_accept_o,
  output logic                        move_reject_o,
  output logic                        turn_timeout_o,
  output logic [$clog2(NCELLS+1)-1:0] move_count_o,
  output logic [2:0]                  state_o,
  output logic [1:0]                  result_o,
  output logic [1:0]                  winner_o
);

  localparam int                 CNT_W       = $clog2(NCELLS + 1);
  localparam int                 OCC_W       = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0]  LAST_IDX    = ADDR_W'(NCELLS - 1);
  localparam logic [ADDR_W:0]    NCELLS_EXT  = (ADDR_W + 1)'(NCELLS);
  localparam logic [CNT_W-1:0]   FULL_CNT    = CNT_W'(NCELLS);
  localparam logic [1:0]         LAST_PLAYER = 2'(NPLAYERS - 1);
  localparam logic [1:0]         NPLAYERS_2  = 2'(NPLAYERS);
  localparam bit                 TMO_EN      = (TIMEOUT > 0);
  localparam logic [TMR_W-1:0]   TMO_LAST    = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

  localparam logic [1:0] RES_NONE = 2'd0;
  localparam logic [1:0] RES_WIN  = 2'd1;
  localparam logic [1:0] RES_TIE  = 2'd2;

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_PLAY  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q,   state_d;
  logic [ADDR_W-1:0]  idx_q,     idx_d;
  logic [OCC_W-1:0]   occ_q,     occ_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [1:0]         cur_q,     cur_d;
  logic [TMR_W-1:0]   tmr_q,     tmr_d;
  logic [1:0]         result_q,  result_d;
  logic [1:0]         winner_q,  winner_d;
  logic               wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [1:0]         wr_data_q, wr_data_d;
  logic               acc_q,     acc_d;
  logic               rej_q,     rej_d;
  logic               tmo_q,     tmo_d;

  logic [1:0]         start_clamped;
  logic [1:0]         next_player;
  logic               move_legal;
  logic               tmo_hit;

  // Operand decode: clamped start player, rotation, move legality, timer expiry.
  always_comb begin
    start_clamped = (start_player_i >= NPLAYERS_2) ? 2'd0 : start_player_i;
    next_player   = (cur_q == LAST_PLAYER) ? 2'd0 : cur_q + 2'd1;
    move_legal    = move_valid_i && ({1'b0, move_addr_i} < NCELLS_EXT) && !occ_q[move_addr_i];
    tmo_hit       = TMO_EN && (tmr_q == TMO_LAST);
  end

  // Next-state and registered-output logic; new_game overrides every state.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    occ_d     = occ_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    tmr_d     = tmr_q;
    result_d  = result_q;
    winner_d  = winner_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    acc_d     = 1'b0;
    rej_d     = 1'b0;
    tmo_d     = 1'b0;

    if (new_game_i) begin
      // Same landing point as reset: sweep restarts on the following edge.
      state_d   = S_CLEAR;
      idx_d     = '0;
      occ_d     = '0;
      cnt_d     = '0;
      cur_d     = start_clamped;
      tmr_d     = '0;
      result_d  = RES_NONE;
      winner_d  = 2'd0;
      wr_addr_d = '0;
      wr_data_d = 2'd0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = 2'd0;
          occ_d     = '0;
          cnt_d     = '0;
          result_d  = RES_NONE;
          winner_d  = 2'd0;
          tmr_d     = '0;
          if (idx_q == LAST_IDX) begin
            state_d = S_PLAY;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        S_PLAY: begin
          if (move_legal) begin
            wr_en_d             = 1'b1;
            wr_addr_d           = move_addr_i;
            wr_data_d           = cur_q + 2'd1;
            acc_d               = 1'b1;
            occ_d[move_addr_i]  = 1'b1;
            cnt_d               = cnt_q + 1'b1;
            state_d             = S_WRITE;
          end else if (tmo_hit) begin
            // Expiry outranks a simultaneous illegal request.
            tmo_d = 1'b1;
            cur_d = next_player;
            tmr_d = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
            rej_d = move_valid_i;
          end
        end
        S_WRITE: begin
          state_d = S_CHECK;
        end
        S_CHECK: begin
          if (win_detect_i) begin
            state_d  = S_DONE;
            result_d = RES_WIN;
            winner_d = cur_q;
          end else if (cnt_q == FULL_CNT) begin
            state_d  = S_DONE;
            result_d = RES_TIE;
          end else begin
            cur_d   = next_player;
            tmr_d   = '0;
            state_d = S_PLAY;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge ph1_i) begin
    if (!reset_i) begin
      state_q   <= S_CLEAR;
      idx_q     <= '0;
      occ_q     <= '0;
      cnt_q     <= '0;
      cur_q     <= start_clamped;
      tmr_q     <= '0;
      result_q  <= RES_NONE;
      winner_q  <= 2'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 2'd0;
      acc_q     <= 1'b0;
      rej_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      occ_q     <= occ_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      tmr_q     <= tmr_d;
      result_q  <= result_d;
      winner_q  <= winner_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      acc_q     <= acc_d;
      rej_q     <= rej_d;
      tmo_q     <= tmo_d;
    end
  end

  assign wr_en_o        = wr_en_q;
  assign wr_addr_o      = wr_addr_q;
  assign wr_data_o      = wr_data_q;
  assign cur_player_o   = cur_q;
  assign move_accept_o  = acc_q;
  assign move_reject_o  = rej_q;
  assign turn_timeout_o = tmo_q;
  assign move_count_o   = cnt_q;
  assign state_o        = state_q;
  assign result_o       = result_q;
  assign winner_o       = winner_q;

endmodule
`default_nettype wire
